// File: rtl/cpc_loader_pkg.sv
// cpc_loader_pkg: shared loader state encoding and default ROM page placement
package cpc_loader_pkg;

    typedef enum logic [1:0] {IDLE, ARM, WRITE} state_t;

    localparam logic [26:0] DEFAULT_PAGE_MAP = {9'h000, 9'h100, 9'h107};

endpackage

// File: rtl/rom_loader.sv
// rom_loader: maps a banked ROM download stream onto paged memory writes paced by ce_ref
module rom_loader
    import cpc_loader_pkg::*;
#(
    parameter int PAGE_BITS = 14,
    parameter int NUM_PAGES = 3,
    parameter int NUM_BANKS = 2,
    parameter logic [9*NUM_PAGES-1:0] PAGE_MAP = DEFAULT_PAGE_MAP,
    parameter int ROM_INDEX = 0,
    localparam int BW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce_ref,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic          mem_we,
    output logic [22:0]   mem_addr,
    output logic [BW-1:0] mem_bank,
    output logic [7:0]    mem_dout,
    output logic          active,
    output logic          done,
    output logic [24:0]   byte_cnt,
    output logic [15:0]   skip_cnt
);

    localparam int SW = 25 - PAGE_BITS;

    state_t        state, state_n;
    logic          qual, wr, rise, hit, pend, skip_inc;
    logic [SW-1:0] src;
    logic [BW-1:0] bank_d;
    logic [8:0]    page_d;

    assign qual     = ioctl_download && ioctl_index == 8'(ROM_INDEX);
    assign wr       = qual && ioctl_wr && state == IDLE;
    assign rise     = qual && !active;
    assign src      = ioctl_addr[24:PAGE_BITS];
    assign skip_inc = wr && !hit && (rise || skip_cnt != 16'hFFFF);

    // Source pages beyond the last bank simply never match an entry
    always_comb begin
        hit    = 1'b0;
        bank_d = '0;
        page_d = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            for (int s = 0; s < NUM_PAGES; s++)
                if (src == SW'(b * NUM_PAGES + s)) begin
                    hit    = 1'b1;
                    bank_d = BW'(b);
                    page_d = PAGE_MAP[(NUM_PAGES-1-s)*9 +: 9];
                end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = wr && hit ? ARM : IDLE;
            ARM:     state_n = ce_ref ? WRITE : ARM;
            WRITE:   state_n = ce_ref ? IDLE : WRITE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            ioctl_wait <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_bank   <= '0;
            mem_dout   <= '0;
            active     <= 1'b0;
            done       <= 1'b0;
            pend       <= 1'b0;
            byte_cnt   <= '0;
            skip_cnt   <= '0;
        end else begin
            state  <= state_n;
            active <= qual;
            if (wr && hit) begin
                mem_dout   <= ioctl_dout;
                mem_addr   <= 23'({page_d, ioctl_addr[PAGE_BITS-1:0]});
                mem_bank   <= bank_d;
                ioctl_wait <= 1'b1;
            end
            if (state == ARM && ce_ref)
                mem_we <= 1'b1;
            if (state == WRITE && ce_ref) begin
                mem_we     <= 1'b0;
                ioctl_wait <= 1'b0;
            end
            byte_cnt <= (rise ? 25'd0 : byte_cnt) + 25'(state == WRITE && ce_ref);
            skip_cnt <= (rise ? 16'd0 : skip_cnt) + 16'(skip_inc);
            // End of download is held until any pending write has drained
            pend <= (active && !qual) || (pend && state != IDLE);
            done <= pend && state == IDLE;
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized download stream checked against a page-mapping reference model
module tb_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset, ce_ref, ioctl_download, ioctl_wr;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [24:0] ioctl_addr;
    logic        ioctl_wait, mem_we, active, done;
    logic [22:0] mem_addr;
    logic [0:0]  mem_bank;
    logic [7:0]  mem_dout;
    logic [24:0] byte_cnt;
    logic [15:0] skip_cnt;

    typedef struct {
        logic [22:0] a;
        logic [0:0]  b;
        logic [7:0]  d;
    } wr_t;

    localparam logic [8:0] MAP [3] = '{9'h000, 9'h100, 9'h107};

    wr_t         exp_q[$];
    int          n_chk = 0, n_err = 0;
    int          exp_bytes = 0, exp_skip = 0, done_cnt = 0, ph = 0;
    logic [31:0] snap;

    rom_loader dut (
        .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_bank(mem_bank), .mem_dout(mem_dout), .active(active), .done(done),
        .byte_cnt(byte_cnt), .skip_cnt(skip_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_sys);
        #1;
    endtask

    // ce_ref pulses every fourth clock; ph lets the stimulus align to it
    initial begin
        ce_ref = 1'b0;
        forever begin
            @(posedge clk_sys);
            #2;
            ph++;
            ce_ref = (ph % 4 == 0);
        end
    end

    initial begin : monitor
        logic we_q;
        int   hi;
        wr_t  e;
        we_q = 1'b0;
        hi   = 0;
        forever begin
            @(negedge clk_sys);
            if (mem_we && !we_q) begin
                hi   = 0;
                snap = {mem_addr, mem_bank, mem_dout};
                if (exp_q.size() == 0)
                    chk("unexpected_we", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("we_addr", 32'(mem_addr), 32'(e.a));
                    chk("we_bank", 32'(mem_bank), 32'(e.b));
                    chk("we_dout", 32'(mem_dout), 32'(e.d));
                end
            end
            if (mem_we)
                hi++;
            if (!mem_we && we_q) begin
                chk("we_len", 32'(hi), 32'd4);
                chk("wait_with_we", 32'(ioctl_wait), 32'd0);
                chk("stable", {mem_addr, mem_bank, mem_dout}, snap);
            end
            if (done) begin
                done_cnt++;
                chk("done_quiet", {30'd0, mem_we, ioctl_wait}, 32'd0);
            end
            we_q = mem_we;
        end
    end

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit dbl, input bit align);
        int  src, bank, slot;
        bit  hit;
        wr_t e;
        src  = int'(a >> 14);
        bank = src / 3;
        slot = src % 3;
        hit  = bank < 2;
        if (align)
            for (int k = 0; k < 8 && (ph + 1) % 4 != 0; k++) step;
        if (hit) begin
            e.a = 23'(int'(MAP[slot]) * 16384 + int'(a % 25'd16384));
            e.b = 1'(bank);
            e.d = d;
            exp_q.push_back(e);
            exp_bytes++;
        end else
            exp_skip++;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        step;
        if (dbl && hit) begin
            ioctl_addr = ~a;
            ioctl_dout = ~d;
            step;
        end
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        if (!(dbl && hit))
            chk("we_early", 32'(mem_we), 32'd0);
        chk("wait_start", 32'(ioctl_wait), 32'(hit));
        for (int k = 0; k < 40 && ioctl_wait; k++) @(negedge clk_sys);
        chk("wait_timeout", 32'(ioctl_wait), 32'd0);
        chk("byte_cnt", 32'(byte_cnt), 32'(exp_bytes));
        chk("skip_cnt", 32'(skip_cnt), 32'(exp_skip));
        step;
    endtask

    initial begin : main
        logic [24:0] a;
        logic [22:0] sa;
        int          d0, sb;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          d0, sb, src;
        logic [22:0] sa;
        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0;
        ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
        repeat (3) step;
        @(negedge clk_sys);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_bank", 32'(mem_bank), 32'd0);
        chk("rst_dout", 32'(mem_dout), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bytes", 32'(byte_cnt), 32'd0);
        chk("rst_skip", 32'(skip_cnt), 32'd0);
        step;
        reset = 1'b0;
        step;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        chk("active_early", 32'(active), 32'd0);
        step;
        @(negedge clk_sys);
        chk("active_rise", 32'(active), 32'd1);
        step;

        send_byte(25'h04005, 8'hA5, 1'b0, 1'b1);
        chk("d1_addr", 32'(mem_addr), 32'h400005);
        chk("d1_bank", 32'(mem_bank), 32'd0);
        chk("d1_dout", 32'(mem_dout), 32'hA5);
        send_byte(25'h14001, 8'h3C, 1'b0, 1'b0);
        chk("d2_addr", 32'(mem_addr), 32'h41C001);
        chk("d2_bank", 32'(mem_bank), 32'd1);
        send_byte(25'h18000, 8'h77, 1'b0, 1'b0);
        chk("d3_addr_held", 32'(mem_addr), 32'h41C001);

        for (int i = 0; i < 40; i++) begin
            src = $urandom_range(0, 7);
            send_byte(25'(src * 16384 + $urandom_range(0, 16383)), 8'($urandom),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3)) step;
        end

        d0 = done_cnt;
        ioctl_download = 1'b0;
        step;
        @(negedge clk_sys);
        chk("end_active", 32'(active), 32'd0);
        chk("end_done_early", 32'(done), 32'd0);
        step;
        @(negedge clk_sys);
        chk("end_done", 32'(done), 32'd1);
        step;
        @(negedge clk_sys);
        chk("end_done_len", 32'(done), 32'd0);
        repeat (4) step;
        chk("end_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("hold_bytes", 32'(byte_cnt), 32'(exp_bytes));
        chk("hold_skip", 32'(skip_cnt), 32'(exp_skip));

        sa = mem_addr; sb = int'(byte_cnt); d0 = done_cnt;
        ioctl_index = 8'd1;
        ioctl_download = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ioctl_addr = 25'($urandom_range(0, 16383));
            ioctl_dout = 8'($urandom);
            ioctl_wr = 1'b1;
            step;
            ioctl_wr = 1'b0;
            step;
        end
        @(negedge clk_sys);
        chk("idx_active", 32'(active), 32'd0);
        chk("idx_wait", 32'(ioctl_wait), 32'd0);
        chk("idx_addr", 32'(mem_addr), 32'(sa));
        chk("idx_bytes", 32'(byte_cnt), 32'(sb));
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        repeat (4) step;
        chk("idx_no_done", 32'(done_cnt - d0), 32'd0);

        ioctl_download = 1'b1;
        step;
        @(negedge clk_sys);
        chk("clr_bytes", 32'(byte_cnt), 32'd0);
        chk("clr_skip", 32'(skip_cnt), 32'd0);
        exp_bytes = 0; exp_skip = 0;
        step;
        d0 = done_cnt;
        exp_q.push_back('{a: 23'h400123, b: 1'b0, d: 8'h5A});
        exp_bytes++;
        ioctl_addr = 25'h04123; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
        step;
        ioctl_wr = 1'b0;
        for (int k = 0; k < 20 && !mem_we; k++) @(negedge clk_sys);
        chk("late_we_seen", 32'(mem_we), 32'd1);
        step;
        ioctl_download = 1'b0;
        repeat (15) step;
        chk("late_done_once", 32'(done_cnt - d0), 32'd1);
        chk("late_bytes", 32'(byte_cnt), 32'(exp_bytes));
        chk("late_active", 32'(active), 32'd0);

        ioctl_download = 1'b1;
        repeat (2) step;
        for (int k = 0; k < 8 && (ph + 1) % 4 != 0; k++) step;
        ioctl_addr = 25'h00042; ioctl_dout = 8'hC3; ioctl_wr = 1'b1;
        step;
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        chk("arm_wait", 32'(ioctl_wait), 32'd1);
        chk("arm_we", 32'(mem_we), 32'd0);
        step;
        reset = 1'b1;
        step;
        @(negedge clk_sys);
        chk("abort_wait", 32'(ioctl_wait), 32'd0);
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_bytes", 32'(byte_cnt), 32'd0);
        step;
        reset = 1'b0;
        ioctl_download = 1'b0;
        repeat (10) step;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
